// File: rtl/cpu_pkg.sv
// Shared loader definitions: FSM state encoding and frame-layout constants.
package cpu_pkg;

  localparam int LDR_LEN_BYTES  = 2;
  localparam int LDR_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } ldr_state_t;

  // Receive states: the loader accepts stream bytes and reports busy.
  function automatic logic is_rx_state(input ldr_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Stream handshake: a byte moves on a clock edge where in_valid && in_ready; in_byte is
// only meaningful while in_valid is high, and in_ready does not depend on in_valid.
interface prog_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output in_valid, in_byte, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input in_valid, in_byte, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/byte_packer.sv
// Packs big-endian stream bytes into 32-bit words; the word is presented combinationally
// together with its 4th byte so the caller can register it with one cycle of latency.
module byte_packer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_idx;
  // Only the first three bytes need storage; the fourth completes the word in place.
  logic [23:0] r_shift;

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_valid) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {r_shift[15:0], i_byte};
    end
  end

  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_valid && (r_idx == 2'(LDR_WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: writes packed words to imem from address 0 and
// releases the CPU from reset only after the payload checksum matches.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  prog_loader_if.slave bus,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output ldr_state_t  o_dbg_state
);

  localparam int LEN_W = 8 * LDR_LEN_BYTES;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(2 ** ADDR_W);

  ldr_state_t        r_state, w_next;
  logic [LEN_W-1:0]  r_len;
  // One bit wider than the address so a full-depth program never wraps before CHK.
  logic [CNT_W-1:0]  r_word_cnt;
  logic [7:0]        r_chk;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst, r_done, r_err;

  logic              w_rx, w_xfer, w_start_ok, w_pack_valid;
  logic              w_word_valid, w_last_word;
  logic [31:0]       w_word;
  logic [LEN_W-1:0]  w_len;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_rx         = is_rx_state(r_state);
  assign w_xfer       = bus.in_valid && w_rx;
  assign w_start_ok   = start && !w_rx;
  assign w_pack_valid = w_xfer && (r_state == ST_DATA);
  assign w_len        = {r_len[LEN_W-1:8], bus.in_byte};
  assign w_cnt_inc    = r_word_cnt + 1'b1;
  assign w_last_word  = (LEN_W'(w_cnt_inc) == r_len);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_valid      (w_pack_valid),
    .i_byte       (bus.in_byte),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_LEN_HI;
      ST_LEN_HI: if (w_xfer) w_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len == '0)                    w_next = ST_CHK;
          else if ({1'b0, w_len} > DEPTH_L)   w_next = ST_ERR;
          else                                w_next = ST_DATA;
        end
      end
      ST_DATA: if (w_word_valid && w_last_word) w_next = ST_CHK;
      ST_CHK: if (w_xfer) w_next = (bus.in_byte == r_chk) ? ST_DONE : ST_ERR;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_chk      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= w_word_valid;
      if (w_start_ok) begin
        r_len      <= '0;
        r_word_cnt <= '0;
        r_chk      <= '0;
        r_cpu_rst  <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end
      if (w_xfer && (r_state == ST_LEN_HI)) r_len[LEN_W-1:8] <= bus.in_byte;
      if (w_xfer && (r_state == ST_LEN_LO)) r_len[7:0] <= bus.in_byte;
      if (w_pack_valid) r_chk <= r_chk ^ bus.in_byte;
      if (w_word_valid) begin
        r_addr     <= r_word_cnt[ADDR_W-1:0];
        r_wdata    <= w_word;
        r_word_cnt <= w_cnt_inc;
      end
      // Status flags change only on entry to a terminal state.
      if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
        r_done    <= 1'b1;
        r_cpu_rst <= 1'b0;
      end
      if ((w_next == ST_ERR) && (r_state != ST_ERR)) r_err <= 1'b1;
    end
  end

  assign bus.in_ready   = w_rx;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign busy           = w_rx;
  assign cpu_rst        = r_cpu_rst;
  assign done           = r_done;
  assign err            = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame vectors from a table plus hand-written corner sequences.
module tb_prog_loader;
  import cpu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int ENT_W  = ADDR_W + 32;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  chk;
    int          gap_max;
    logic        exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cpu_rst, busy, done, err;
  ldr_state_t dbg_state;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int stalls   = 0;
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] got_q[$];

  always @(posedge clk) begin
    #1;
    if (bus.imem_we) got_q.push_back({bus.imem_addr, bus.imem_wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic score(input string name);
    check({name, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [ENT_W-1:0] e;
      logic [ENT_W-1:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({name, " addr"}, 32'(g[ENT_W-1:32]), 32'(e[ENT_W-1:32]));
      check({name, " data"}, g[31:0], e[31:0]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_reset(input string name);
    check({name, " cpu_rst"},  32'(cpu_rst), 32'd1);
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, " imem_we"},  32'(bus.imem_we), 32'd0);
    check({name, " imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check({name, " imem_wdata"}, bus.imem_wdata, 32'd0);
    check({name, " busy"},     32'(busy), 32'd0);
    check({name, " done"},     32'(done), 32'd0);
    check({name, " err"},      32'(err), 32'd0);
    check({name, " state"},    32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int tries;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    tries = 0;
    while (!bus.in_ready && tries < 20) begin
      stalls++;
      tries++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("in_ready timeout", 32'd0, 32'd1);
    else @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    send_byte(w[31:24], gap_max);
    send_byte(w[23:16], gap_max);
    send_byte(w[15:8],  gap_max);
    send_byte(w[7:0],   gap_max);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] word_for(input int i);
    return {8'(i), 8'(i >> 8), 8'hC3, 8'(i * 7)};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t        vecs[7];
    logic [15:0] len;
    logic [31:0] w;
    logic [7:0]  c;

    // Frame checksums are XOR of payload bytes, computed by hand.
    vecs[0] = '{16'd2, 32'h2002_0005, 32'h0000_0020, 8'h07, 0, 1'b1};
    vecs[1] = '{16'd2, 32'h2002_0005, 32'h0000_0020, 8'h26, 0, 1'b0};
    vecs[2] = '{16'd0, 32'h0,         32'h0,         8'h00, 0, 1'b1};
    vecs[3] = '{16'd0, 32'h0,         32'h0,         8'h5A, 0, 1'b0};
    vecs[4] = '{16'd1, 32'hDEAD_BEEF, 32'h0,         8'h22, 0, 1'b1};
    vecs[5] = '{16'd2, 32'h2002_0005, 32'h0000_0020, 8'h07, 3, 1'b1};
    vecs[6] = '{16'd2, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 2, 1'b1};

    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // Bytes offered while idle must be ignored.
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h55;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("idle state", 32'(dbg_state), 32'(ST_IDLE));
    check("idle busy", 32'(busy), 32'd0);
    score("idle");

    for (int i = 0; i < 7; i++) begin
      pulse_start();
      check($sformatf("vec%0d start cpu_rst", i), 32'(cpu_rst), 32'd1);
      check($sformatf("vec%0d start done", i), 32'(done), 32'd0);
      check($sformatf("vec%0d start err", i), 32'(err), 32'd0);
      check($sformatf("vec%0d start busy", i), 32'(busy), 32'd1);
      stalls = 0;
      send_byte(vecs[i].n[15:8], vecs[i].gap_max);
      send_byte(vecs[i].n[7:0], vecs[i].gap_max);
      if (vecs[i].n > 0) begin
        exp_q.push_back({ADDR_W'(0), vecs[i].w0});
        send_word(vecs[i].w0, vecs[i].gap_max);
      end
      if (vecs[i].n > 1) begin
        exp_q.push_back({ADDR_W'(1), vecs[i].w1});
        send_word(vecs[i].w1, vecs[i].gap_max);
      end
      send_byte(vecs[i].chk, vecs[i].gap_max);
      score($sformatf("vec%0d", i));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d err", i), 32'(err), 32'(!vecs[i].exp_done));
      check($sformatf("vec%0d cpu_rst", i), 32'(cpu_rst), 32'(!vecs[i].exp_done));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d state", i), 32'(dbg_state),
            32'(vecs[i].exp_done ? ST_DONE : ST_ERR));
      check($sformatf("vec%0d stalls", i), 32'(stalls), 32'd0);
    end

    // start pulsed in the middle of DATA is ignored.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    pulse_start();
    check("mid start state", 32'(dbg_state), 32'(ST_DATA));
    check("mid start cpu_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'hEF, 0);
    send_byte(8'h01, 0);
    exp_q.push_back({ADDR_W'(0), 32'hABCD_EF01});
    send_byte(8'h88, 0);
    score("mid start");
    check("mid start done", 32'(done), 32'd1);

    // Reset held for two cycles after one word has been written.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h2002_0005, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({ADDR_W'(0), 32'h2002_0005});
    score("pre reset");
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("mid reset");
    rst = 1'b1;
    @(negedge clk);
    check("post reset state", 32'(dbg_state), 32'(ST_IDLE));

    // Length one past capacity fails right after LEN_LO.
    pulse_start();
    len = 16'(DEPTH + 1);
    send_byte(len[15:8], 0);
    send_byte(len[7:0], 0);
    check("oversize err", 32'(err), 32'd1);
    check("oversize state", 32'(dbg_state), 32'(ST_ERR));
    check("oversize in_ready", 32'(bus.in_ready), 32'd0);
    check("oversize cpu_rst", 32'(cpu_rst), 32'd1);
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    score("oversize");

    // Full-capacity program: last write lands at DEPTH-1 and the load completes.
    pulse_start();
    len = 16'(DEPTH);
    send_byte(len[15:8], 0);
    send_byte(len[7:0], 0);
    c = 8'h00;
    stalls = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = word_for(i);
      c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_q.push_back({ADDR_W'(i), w});
      send_word(w, 0);
    end
    check("full state chk", 32'(dbg_state), 32'(ST_CHK));
    send_byte(c, 0);
    score("full");
    check("full last addr", 32'(bus.imem_addr), 32'(DEPTH - 1));
    check("full done", 32'(done), 32'd1);
    check("full cpu_rst", 32'(cpu_rst), 32'd0);
    check("full stalls", 32'(stalls), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
